// File: rtl/demux_deser_pkg.sv
// Shared definitions for the 4-channel demux deserializer: channel sizing,
// channel index type, output FSM states and the round-robin pick helper.
package demux_deser_pkg;

    localparam int CH_N = 4;
    localparam int CH_W = 2;

    typedef logic [CH_W-1:0] ch_idx_t;

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        PRESENT = 1'b1
    } state_t;

    typedef struct packed {
        logic    found;
        ch_idx_t ch;
    } rr_pick_t;

    // First full channel scanning ptr, ptr+1, ... with natural 2-bit wrap.
    function automatic rr_pick_t rr_pick(input logic [CH_N-1:0] full, input ch_idx_t ptr);
        rr_pick_t res;
        ch_idx_t  idx;
        res.found = 1'b0;
        res.ch    = ptr;
        for (int i = 0; i < CH_N; i++) begin
            idx = ptr + ch_idx_t'(i);
            if (!res.found && full[idx]) begin
                res.found = 1'b1;
                res.ch    = idx;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/demux_deser_lane.sv
// One deserializer channel: shifts in serial bits, buffers one complete word
// and flags a sticky overflow when a word completes while the buffer is busy.
module demux_deser_lane
    import demux_deser_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             bit_en,
    input  logic             bit_in,
    input  logic             pop,
    input  logic             ovf_clr,
    output logic [WIDTH-1:0] hold,
    output logic             hold_full,
    output logic             ovf
);

    localparam int CNT_W = $clog2(WIDTH);

    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic             hold_full_q, hold_full_d;
    logic             ovf_q, ovf_d;
    logic [WIDTH-1:0] word_s;
    logic             complete_s;

    // Next-state for assembly, word buffer and overflow flag.
    always_comb begin
        word_s      = {shreg_q[WIDTH-2:0], bit_in};
        complete_s  = bit_en && (cnt_q == CNT_W'(WIDTH-1));
        shreg_d     = shreg_q;
        cnt_d       = cnt_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        ovf_d       = ovf_q;

        if (bit_en) begin
            shreg_d = word_s;
            if (complete_s) begin
                cnt_d = {CNT_W{1'b0}};
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else begin
            cnt_d = cnt_q;
        end

        if (ovf_clr) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end

        if (pop) begin
            hold_full_d = 1'b0;
        end else begin
            hold_full_d = hold_full_q;
        end

        // A completing word may reuse the buffer being popped this cycle;
        // otherwise it is dropped, and the overflow set overrides a clear.
        if (complete_s) begin
            if (!hold_full_q || pop) begin
                hold_d      = word_s;
                hold_full_d = 1'b1;
            end else begin
                ovf_d = 1'b1;
            end
        end else begin
            hold_d = hold_q;
        end
    end

    // Lane state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg_q     <= {WIDTH{1'b0}};
            cnt_q       <= {CNT_W{1'b0}};
            hold_q      <= {WIDTH{1'b0}};
            hold_full_q <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            shreg_q     <= shreg_d;
            cnt_q       <= cnt_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            ovf_q       <= ovf_d;
        end
    end

    assign hold      = hold_q;
    assign hold_full = hold_full_q;
    assign ovf       = ovf_q;

endmodule

// File: rtl/demux_deser4.sv
// Four-channel deserializer behind a 1:4 bit demux. Each lane assembles its
// own words; a round-robin output FSM presents buffered words one at a time.
module demux_deser4
    import demux_deser_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             bit_vld,
    input  logic [1:0]       sel,
    input  logic [3:0]       y,
    output logic             out_vld,
    input  logic             out_rdy,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       out_ch,
    output logic [3:0]       ovf,
    input  logic             ovf_clr
);

    state_t           state_q, state_d;
    logic             out_vld_q, out_vld_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    ch_idx_t          out_ch_q, out_ch_d;
    ch_idx_t          rr_ptr_q, rr_ptr_d;

    logic [CH_N-1:0]  bit_en_s;
    logic [CH_N-1:0]  pop_s;
    logic [CH_N-1:0]  hold_full_s;
    logic [CH_N-1:0]  ovf_s;
    logic [WIDTH-1:0] hold_s [CH_N];
    logic             handshake_s;
    rr_pick_t         pick_s;

    assign handshake_s = (state_q == PRESENT) && out_vld_q && out_rdy;
    assign pick_s      = rr_pick(hold_full_s, rr_ptr_q);

    for (genvar c = 0; c < CH_N; c++) begin : g_lane
        assign bit_en_s[c] = bit_vld && (sel == ch_idx_t'(c));
        assign pop_s[c]    = handshake_s && (out_ch_q == ch_idx_t'(c));

        demux_deser_lane #(
            .WIDTH (WIDTH)
        ) u_lane (
            .clk       (clk),
            .rst_n     (rst_n),
            .bit_en    (bit_en_s[c]),
            .bit_in    (y[c]),
            .pop       (pop_s[c]),
            .ovf_clr   (ovf_clr),
            .hold      (hold_s[c]),
            .hold_full (hold_full_s[c]),
            .ovf       (ovf_s[c])
        );
    end

    // Output FSM next-state: pick a full lane in IDLE, hold it until accepted.
    always_comb begin
        state_d    = state_q;
        out_vld_d  = out_vld_q;
        out_data_d = out_data_q;
        out_ch_d   = out_ch_q;
        rr_ptr_d   = rr_ptr_q;

        case (state_q)
            IDLE: begin
                if (pick_s.found) begin
                    state_d    = PRESENT;
                    out_vld_d  = 1'b1;
                    out_data_d = hold_s[pick_s.ch];
                    out_ch_d   = pick_s.ch;
                end else begin
                    out_vld_d  = 1'b0;
                end
            end
            PRESENT: begin
                if (handshake_s) begin
                    state_d   = IDLE;
                    out_vld_d = 1'b0;
                    rr_ptr_d  = out_ch_q + ch_idx_t'(1);
                end else begin
                    out_vld_d = 1'b1;
                end
            end
            default: begin
                state_d   = IDLE;
                out_vld_d = 1'b0;
            end
        endcase
    end

    // Output FSM and presented-word registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            out_vld_q  <= 1'b0;
            out_data_q <= {WIDTH{1'b0}};
            out_ch_q   <= {CH_W{1'b0}};
            rr_ptr_q   <= {CH_W{1'b0}};
        end else begin
            state_q    <= state_d;
            out_vld_q  <= out_vld_d;
            out_data_q <= out_data_d;
            out_ch_q   <= out_ch_d;
            rr_ptr_q   <= rr_ptr_d;
        end
    end

    assign out_vld  = out_vld_q;
    assign out_data = out_data_q;
    assign out_ch   = out_ch_q;
    assign ovf      = ovf_s;

endmodule

// File: tb/tb_demux_deser4.sv
// Directed self-checking bench for demux_deser4 with WIDTH=8.
module tb_demux_deser4;

    logic       clk;
    logic       rst_n;
    logic       bit_vld;
    logic [1:0] sel;
    logic [3:0] y;
    logic       out_vld;
    logic       out_rdy;
    logic [7:0] out_data;
    logic [1:0] out_ch;
    logic [3:0] ovf;
    logic       ovf_clr;

    int tests = 0;
    int fails = 0;

    logic [7:0] w;
    logic [7:0] w4 [4];
    logic [1:0] order [4];

    demux_deser4 #(.WIDTH(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bit_vld  (bit_vld),
        .sel      (sel),
        .y        (y),
        .out_vld  (out_vld),
        .out_rdy  (out_rdy),
        .out_data (out_data),
        .out_ch   (out_ch),
        .ovf      (ovf),
        .ovf_clr  (ovf_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One valid bit on channel ch; unused demux lines carry the inverse.
    task automatic send_bit(input logic [1:0] ch, input logic b);
        sel     = ch;
        y       = {4{~b}};
        y[ch]   = b;
        bit_vld = 1'b1;
        tick();
        bit_vld = 1'b0;
        y       = 4'h0;
    endtask

    task automatic send_word(input logic [1:0] ch, input logic [7:0] word);
        for (int i = 7; i >= 0; i--) send_bit(ch, word[i]);
    endtask

    initial begin
        rst_n   = 1'b0;
        bit_vld = 1'b0;
        sel     = 2'd0;
        y       = 4'h0;
        out_rdy = 1'b0;
        ovf_clr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_vld",  32'(out_vld),  32'h0);
        check("reset_data", 32'(out_data), 32'h0);
        check("reset_ch",   32'(out_ch),   32'h0);
        check("reset_ovf",  32'(ovf),      32'h0);
        rst_n = 1'b1;

        // 1: single word B2 on ch2, one-cycle latency to out_vld.
        out_rdy = 1'b1;
        send_word(2'd2, 8'hB2);
        check("t1_vld_latency", 32'(out_vld), 32'h0);
        tick();
        check("t1_vld",  32'(out_vld),  32'h1);
        check("t1_data", 32'(out_data), 32'hB2);
        check("t1_ch",   32'(out_ch),   32'h2);
        check("t1_ovf",  32'(ovf),      32'h0);
        tick();
        check("t1_popped", 32'(out_vld), 32'h0);

        // 3: stalled consumer, two words on ch3 -> second dropped, ovf[3].
        out_rdy = 1'b0;
        send_word(2'd3, 8'hA5);
        send_word(2'd3, 8'h3C);
        check("t3_vld",  32'(out_vld),  32'h1);
        check("t3_data", 32'(out_data), 32'hA5);
        check("t3_ch",   32'(out_ch),   32'h3);
        check("t3_ovf",  32'(ovf),      32'h8);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        check("t3_ovf_clr",   32'(ovf),      32'h0);
        check("t3_data_held", 32'(out_data), 32'hA5);
        out_rdy = 1'b1;
        tick();
        check("t3_popped", 32'(out_vld), 32'h0);
        tick();
        check("t3_dropped", 32'(out_vld), 32'h0);

        // 2: interleaved ch0 (0F) and ch1 (F0), ch0 first.
        out_rdy = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            w = 8'h0F;
            send_bit(2'd0, w[i]);
            w = 8'hF0;
            send_bit(2'd1, w[i]);
        end
        check("t2_vld0",  32'(out_vld),  32'h1);
        check("t2_ch0",   32'(out_ch),   32'h0);
        check("t2_data0", 32'(out_data), 32'h0F);
        out_rdy = 1'b1;
        tick();
        check("t2_bubble", 32'(out_vld), 32'h0);
        tick();
        check("t2_vld1",  32'(out_vld),  32'h1);
        check("t2_ch1",   32'(out_ch),   32'h1);
        check("t2_data1", 32'(out_data), 32'hF0);
        tick();
        check("t2_popped", 32'(out_vld), 32'h0);

        // 4: all four lanes full, rr_ptr=2 -> ch2, ch3, ch0, ch1.
        out_rdy  = 1'b0;
        w4[0] = 8'hC3;
        w4[1] = 8'h5A;
        w4[2] = 8'h96;
        w4[3] = 8'h71;
        order[0] = 2'd2;
        order[1] = 2'd3;
        order[2] = 2'd0;
        order[3] = 2'd1;
        for (int i = 7; i >= 0; i--) begin
            for (int k = 0; k < 4; k++) begin
                w = w4[order[k]];
                send_bit(order[k], w[i]);
            end
        end
        check("t4_ovf", 32'(ovf), 32'h0);
        out_rdy = 1'b1;
        for (int k = 0; k < 4; k++) begin
            check("t4_vld",  32'(out_vld),  32'h1);
            check("t4_ch",   32'(out_ch),   32'(order[k]));
            check("t4_data", 32'(out_data), 32'(w4[order[k]]));
            tick();
            check("t4_bubble", 32'(out_vld), 32'h0);
            if (k < 3) tick();
        end

        // 5: ch1 completes a word in the same cycle its held word is popped.
        out_rdy = 1'b0;
        send_word(2'd1, 8'hE7);
        w = 8'h4D;
        for (int i = 7; i >= 1; i--) send_bit(2'd1, w[i]);
        check("t5_vld_old",  32'(out_vld),  32'h1);
        check("t5_data_old", 32'(out_data), 32'hE7);
        check("t5_ch_old",   32'(out_ch),   32'h1);
        out_rdy = 1'b1;
        send_bit(2'd1, w[0]);
        check("t5_bubble", 32'(out_vld), 32'h0);
        check("t5_ovf",    32'(ovf),     32'h0);
        tick();
        check("t5_vld_new",  32'(out_vld),  32'h1);
        check("t5_data_new", 32'(out_data), 32'h4D);
        check("t5_ch_new",   32'(out_ch),   32'h1);
        tick();
        check("t5_popped", 32'(out_vld), 32'h0);

        // 6: reset mid-word and mid-handshake, then a clean word.
        out_rdy = 1'b0;
        send_word(2'd2, 8'h69);
        send_word(2'd2, 8'h12);
        check("t6_pre_vld", 32'(out_vld),  32'h1);
        check("t6_pre_ovf", 32'(ovf),      32'h4);
        for (int i = 0; i < 5; i++) send_bit(2'd0, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_rst_vld",  32'(out_vld),  32'h0);
        check("t6_rst_data", 32'(out_data), 32'h0);
        check("t6_rst_ch",   32'(out_ch),   32'h0);
        check("t6_rst_ovf",  32'(ovf),      32'h0);
        #2;
        rst_n   = 1'b1;
        out_rdy = 1'b1;
        send_word(2'd0, 8'h5C);
        check("t6_latency", 32'(out_vld), 32'h0);
        tick();
        check("t6_vld",  32'(out_vld),  32'h1);
        check("t6_data", 32'(out_data), 32'h5C);
        check("t6_ch",   32'(out_ch),   32'h0);
        tick();
        check("t6_popped", 32'(out_vld), 32'h0);
        tick();
        check("t6_nothing_left", 32'(out_vld), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
